// File: rtl/ace_snoop_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ace_snoop_responder_pkg
// Description : Shared ACE snoop definitions. Provides the snoop-type
//               encoding, the CRRESP packed structure with its bit indices,
//               and the pure response/state-update decode used by the
//               snoop responder.
// Contents    : ac_snoop_e, crresp_t, CRRESP_*_BIT, snoop_dec_t,
//               snoop_needs_lookup(), snoop_decode()
// Revision    : 1.0 - initial release
// ============================================================================
package ace_snoop_responder_pkg;

  typedef enum logic [3:0] {
    AC_READ_ONCE             = 4'd0,
    AC_READ_SHARED           = 4'd1,
    AC_READ_CLEAN            = 4'd2,
    AC_READ_NOT_SHARED_DIRTY = 4'd3,
    AC_READ_UNIQUE           = 4'd4,
    AC_CLEAN_SHARED          = 4'd5,
    AC_CLEAN_INVALID         = 4'd6,
    AC_MAKE_INVALID          = 4'd7,
    AC_DVM_COMPLETE          = 4'd8,
    AC_DVM_MESSAGE           = 4'd9
  } ac_snoop_e;

  // First member lands in the MSB: {WasUnique,IsShared,PassDirty,Error,DataTransfer}
  typedef struct packed {
    logic was_unique;
    logic is_shared;
    logic pass_dirty;
    logic error;
    logic data_transfer;
  } crresp_t;

  localparam int CRRESP_DATA_TRANSFER_BIT = 0;
  localparam int CRRESP_ERROR_BIT         = 1;
  localparam int CRRESP_PASS_DIRTY_BIT    = 2;
  localparam int CRRESP_IS_SHARED_BIT     = 3;
  localparam int CRRESP_WAS_UNIQUE_BIT    = 4;

  typedef struct packed {
    crresp_t resp;
    logic    upd;    // a state update applies to the local line
    logic    inval;  // update kind: invalidate
    logic    clean;  // update kind: mark SharedClean
  } snoop_dec_t;

  // Types 8 and above (DVM and reserved) never touch the cache tags.
  function automatic logic snoop_needs_lookup(input logic [3:0] snoop);
    return ~snoop[3];
  endfunction

  function automatic snoop_dec_t snoop_decode(input logic [3:0] snoop,
                                              input logic       hit,
                                              input logic       dirty,
                                              input logic       uniq);
    logic [4:0] r;
    snoop_dec_t d;
    r = '0;
    d = '0;
    if (snoop > 4'd9) begin
      r[CRRESP_ERROR_BIT] = 1'b1;
    end else if (snoop_needs_lookup(snoop) && hit) begin
      r[CRRESP_WAS_UNIQUE_BIT] = uniq;
      case (ac_snoop_e'(snoop))
        AC_READ_ONCE: begin
          r[CRRESP_DATA_TRANSFER_BIT] = 1'b1;
          r[CRRESP_IS_SHARED_BIT]     = 1'b1;
        end
        AC_READ_SHARED, AC_READ_CLEAN, AC_READ_NOT_SHARED_DIRTY: begin
          r[CRRESP_DATA_TRANSFER_BIT] = 1'b1;
          r[CRRESP_PASS_DIRTY_BIT]    = dirty;
          r[CRRESP_IS_SHARED_BIT]     = 1'b1;
          d.clean                     = 1'b1;
        end
        AC_READ_UNIQUE: begin
          r[CRRESP_DATA_TRANSFER_BIT] = 1'b1;
          r[CRRESP_PASS_DIRTY_BIT]    = dirty;
          d.inval                     = 1'b1;
        end
        AC_CLEAN_SHARED: begin
          r[CRRESP_DATA_TRANSFER_BIT] = dirty;
          r[CRRESP_PASS_DIRTY_BIT]    = dirty;
          r[CRRESP_IS_SHARED_BIT]     = 1'b1;
          d.clean                     = dirty;
        end
        AC_CLEAN_INVALID: begin
          r[CRRESP_DATA_TRANSFER_BIT] = dirty;
          r[CRRESP_PASS_DIRTY_BIT]    = dirty;
          d.inval                     = 1'b1;
        end
        AC_MAKE_INVALID: begin
          d.inval = 1'b1;
        end
        default: begin
        end
      endcase
    end
    d.resp = crresp_t'(r);
    d.upd  = d.inval | d.clean;
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ace_snoop_cd_serializer.sv
`default_nettype none
// ============================================================================
// Module      : ace_snoop_cd_serializer
// Description : Holds one cache line and streams it onto the ACE CD channel,
//               beat 0 first, once started by a one-cycle start pulse.
// Ports       : clk, rst_n (async, active-low)
//               i_load/i_line   - capture the line to be sent
//               i_start         - begin streaming (one-cycle pulse)
//               i_cd_ready      - CD ready from interconnect
//               o_cd_valid/o_cd_data/o_cd_last - CD beat outputs
//               o_done          - last beat accepted this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module ace_snoop_cd_serializer #(
  parameter int DATA_WIDTH = 64,
  parameter int LINE_BEATS = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_load,
  input  logic [DATA_WIDTH*LINE_BEATS-1:0] i_line,
  input  logic                             i_start,
  input  logic                             i_cd_ready,
  output logic                             o_cd_valid,
  output logic [DATA_WIDTH-1:0]            o_cd_data,
  output logic                             o_cd_last,
  output logic                             o_done
);

  localparam int              BEAT_W      = $clog2(LINE_BEATS);
  localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  logic [DATA_WIDTH*LINE_BEATS-1:0] r_line;
  logic [BEAT_W-1:0]                r_beat;
  logic                             r_active;

  logic [DATA_WIDTH-1:0]            w_beats [LINE_BEATS];
  logic                             w_hs;
  logic                             w_last;

  generate
    for (genvar g = 0; g < LINE_BEATS; g++) begin : g_beat_slice
      assign w_beats[g] = r_line[g*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign w_hs   = r_active & i_cd_ready;
  assign w_last = (r_beat == C_LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line   <= '0;
      r_beat   <= '0;
      r_active <= 1'b0;
    end else begin
      if (i_load) begin
        r_line <= i_line;
      end
      if (i_start) begin
        r_active <= 1'b1;
        r_beat   <= '0;
      end else if (w_hs) begin
        if (w_last) begin
          r_active <= 1'b0;
          r_beat   <= '0;
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end
    end
  end

  assign o_cd_valid = r_active;
  assign o_cd_data  = r_active ? w_beats[r_beat] : '0;
  assign o_cd_last  = r_active & w_last;
  assign o_done     = w_hs & w_last;

endmodule
`default_nettype wire

// File: rtl/ace_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module      : ace_snoop_responder
// Description : Cache-side ACE snoop responder. Accepts one AC snoop at a
//               time, looks the line up in the local cache, returns CRRESP,
//               streams the line on CD when data is transferred and pulses a
//               state-update command back to the cache.
// Ports       : clk_i, rst_ni (async, active-low)
//               ac_*  - snoop request channel (in)
//               cr_*  - snoop response channel (out)
//               cd_*  - snoop data channel (out)
//               lu_*  - cache tag/state lookup port (req/gnt, rvalid result)
//               upd_* - one-cycle cache state-update command
// Revision    : 1.0 - initial release
// ============================================================================
module ace_snoop_responder
  import ace_snoop_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int LINE_BEATS = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             ac_valid_i,
  output logic                             ac_ready_o,
  input  logic [ADDR_WIDTH-1:0]            ac_addr_i,
  input  logic [3:0]                       ac_snoop_i,
  input  logic [2:0]                       ac_prot_i,
  output logic                             cr_valid_o,
  input  logic                             cr_ready_i,
  output logic [4:0]                       cr_resp_o,
  output logic                             cd_valid_o,
  input  logic                             cd_ready_i,
  output logic [DATA_WIDTH-1:0]            cd_data_o,
  output logic                             cd_last_o,
  output logic                             lu_req_o,
  input  logic                             lu_gnt_i,
  output logic [ADDR_WIDTH-1:0]            lu_addr_o,
  input  logic                             lu_rvalid_i,
  input  logic                             lu_hit_i,
  input  logic                             lu_dirty_i,
  input  logic                             lu_unique_i,
  input  logic [DATA_WIDTH*LINE_BEATS-1:0] lu_data_i,
  output logic                             upd_valid_o,
  output logic                             upd_inval_o,
  output logic                             upd_clean_o
);

  localparam int OFFSET_W = $clog2(DATA_WIDTH / 8 * LINE_BEATS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LREQ  = 3'd1;
  localparam logic [2:0] S_LWAIT = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;

  logic [2:0]            r_state;
  logic [2:0]            w_next;
  logic                  r_ac_ready;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_snoop;
  logic [2:0]            r_prot;
  crresp_t               r_resp;
  logic                  r_upd_valid;
  logic                  r_upd_inval;
  logic                  r_upd_clean;

  snoop_dec_t            w_dec_ac;
  snoop_dec_t            w_dec_lu;
  logic                  w_ac_hs;
  logic                  w_ac_direct;
  logic                  w_lu_done;
  logic                  w_cr_hs;
  logic                  w_cd_start;
  logic                  w_cd_done;
  logic                  w_unused_misc;

  // Lookup-free snoops decode straight from the AC inputs; the hit inputs
  // are irrelevant for them.
  assign w_dec_ac    = snoop_decode(ac_snoop_i, 1'b0, 1'b0, 1'b0);
  assign w_dec_lu    = snoop_decode(r_snoop, lu_hit_i, lu_dirty_i, lu_unique_i);

  assign w_ac_hs     = ac_valid_i & r_ac_ready;
  assign w_ac_direct = ~snoop_needs_lookup(ac_snoop_i);
  assign w_lu_done   = (r_state == S_LWAIT) & lu_rvalid_i;
  assign w_cr_hs     = cr_valid_o & cr_ready_i;
  assign w_cd_start  = w_cr_hs & r_resp.data_transfer;

  // Offset bits and the stored protection are intentionally not consumed.
  assign w_unused_misc = ^{r_addr[OFFSET_W-1:0], r_prot,
                           w_dec_ac.upd, w_dec_ac.inval, w_dec_ac.clean};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_ac_hs)     w_next = w_ac_direct ? S_RESP : S_LREQ;
      S_LREQ:  if (lu_gnt_i)    w_next = S_LWAIT;
      S_LWAIT: if (lu_rvalid_i) w_next = S_RESP;
      S_RESP:  if (cr_ready_i)  w_next = r_resp.data_transfer ? S_DATA : S_IDLE;
      S_DATA:  if (w_cd_done)   w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_ac_ready  <= 1'b0;
      r_addr      <= '0;
      r_snoop     <= '0;
      r_prot      <= '0;
      r_resp      <= '0;
      r_upd_valid <= 1'b0;
      r_upd_inval <= 1'b0;
      r_upd_clean <= 1'b0;
    end else begin
      r_state <= w_next;
      // Registered ready keeps ac_ready_o low during reset and rises one
      // cycle after release; otherwise it tracks "state is IDLE".
      r_ac_ready <= (w_next == S_IDLE);
      if (w_ac_hs) begin
        r_addr  <= ac_addr_i;
        r_snoop <= ac_snoop_i;
        r_prot  <= ac_prot_i;
      end
      if (w_ac_hs && w_ac_direct) begin
        r_resp <= w_dec_ac.resp;
      end else if (w_lu_done) begin
        r_resp <= w_dec_lu.resp;
      end
      // Lands exactly in the first RESP cycle, one cycle wide.
      r_upd_valid <= w_lu_done & w_dec_lu.upd;
      r_upd_inval <= w_lu_done & w_dec_lu.inval;
      r_upd_clean <= w_lu_done & w_dec_lu.clean;
    end
  end

  ace_snoop_cd_serializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINE_BEATS (LINE_BEATS)
  ) u_cd_serializer (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .i_load     (w_lu_done),
    .i_line     (lu_data_i),
    .i_start    (w_cd_start),
    .i_cd_ready (cd_ready_i),
    .o_cd_valid (cd_valid_o),
    .o_cd_data  (cd_data_o),
    .o_cd_last  (cd_last_o),
    .o_done     (w_cd_done)
  );

  assign ac_ready_o  = r_ac_ready;
  assign lu_req_o    = (r_state == S_LREQ);
  assign lu_addr_o   = {r_addr[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign cr_valid_o  = (r_state == S_RESP);
  assign cr_resp_o   = cr_valid_o ? r_resp : 5'd0;
  assign upd_valid_o = r_upd_valid;
  assign upd_inval_o = r_upd_inval;
  assign upd_clean_o = r_upd_clean;

endmodule
`default_nettype wire

// File: tb/tb_ace_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ace_snoop_responder
// Description : Self-checking bench for ace_snoop_responder. Directed
//               scenarios followed by randomized snoops, all checked against
//               a table-level model of the snoop response rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ace_snoop_responder;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ac_valid, cr_ready, cd_ready, lu_gnt, lu_rvalid;
  logic          lu_hit, lu_dirty, lu_uniq;
  logic [AW-1:0] ac_addr;
  logic [3:0]    ac_snoop;
  logic [2:0]    ac_prot;
  logic [DW*LB-1:0] lu_data;

  logic          ac_ready_o, cr_valid_o, cd_valid_o, cd_last_o, lu_req_o;
  logic [4:0]    cr_resp_o;
  logic [DW-1:0] cd_data_o;
  logic [AW-1:0] lu_addr_o;
  logic          upd_valid_o, upd_inval_o, upd_clean_o;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  int   upd_total = 0;
  logic upd_inv_seen = 1'b0;
  logic upd_cln_seen = 1'b0;

  always #5 clk = ~clk;

  ace_snoop_responder dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .ac_valid_i  (ac_valid),
    .ac_ready_o  (ac_ready_o),
    .ac_addr_i   (ac_addr),
    .ac_snoop_i  (ac_snoop),
    .ac_prot_i   (ac_prot),
    .cr_valid_o  (cr_valid_o),
    .cr_ready_i  (cr_ready),
    .cr_resp_o   (cr_resp_o),
    .cd_valid_o  (cd_valid_o),
    .cd_ready_i  (cd_ready),
    .cd_data_o   (cd_data_o),
    .cd_last_o   (cd_last_o),
    .lu_req_o    (lu_req_o),
    .lu_gnt_i    (lu_gnt),
    .lu_addr_o   (lu_addr_o),
    .lu_rvalid_i (lu_rvalid),
    .lu_hit_i    (lu_hit),
    .lu_dirty_i  (lu_dirty),
    .lu_unique_i (lu_uniq),
    .lu_data_i   (lu_data),
    .upd_valid_o (upd_valid_o),
    .upd_inval_o (upd_inval_o),
    .upd_clean_o (upd_clean_o)
  );

  // Update pulses counted mid-cycle; the last seen kind is remembered.
  always @(negedge clk) begin
    if (upd_valid_o === 1'b1) begin
      upd_total    <= upd_total + 1;
      upd_inv_seen <= upd_inval_o;
      upd_cln_seen <= upd_clean_o;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Response table expressed directly from the snoop rules.
  task automatic model(input int t, input bit hit, input bit dirty, input bit uq,
                       output logic [4:0] resp, output bit lookup,
                       output bit upd, output bit inval, output bit clean);
    bit wu, is, pd, er, dt;
    lookup = (t < 8);
    wu = 0; is = 0; pd = 0; er = 0; dt = 0; inval = 0; clean = 0;
    if (t >= 10) er = 1;
    else if (lookup && hit) begin
      wu = uq;
      case (t)
        0:       begin dt = 1; is = 1; end
        1, 2, 3: begin dt = 1; pd = dirty; is = 1; clean = 1; end
        4:       begin dt = 1; pd = dirty; inval = 1; end
        5:       begin dt = dirty; pd = dirty; is = 1; clean = dirty; end
        6:       begin dt = dirty; pd = dirty; inval = 1; end
        default: begin inval = 1; end
      endcase
    end
    resp = {wu, is, pd, er, dt};
    upd  = inval | clean;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ac_ready"}, ac_ready_o, 0);
    check({tag, "_cr_valid"}, cr_valid_o, 0);
    check({tag, "_cr_resp"},  cr_resp_o, 0);
    check({tag, "_cd_valid"}, cd_valid_o, 0);
    check({tag, "_cd_data"},  cd_data_o, 0);
    check({tag, "_cd_last"},  cd_last_o, 0);
    check({tag, "_lu_req"},   lu_req_o, 0);
    check({tag, "_lu_addr"},  lu_addr_o, 0);
    check({tag, "_upd"},      {upd_valid_o, upd_inval_o, upd_clean_o}, 0);
  endtask

  // cd_mode: 0 always ready, 1 toggle starting low, 2 random.
  task automatic snoop(input int t, input logic [AW-1:0] addr,
                       input bit hit, input bit dirty, input bit uq,
                       input logic [DW*LB-1:0] line, input int gnt_dly,
                       input int rv_dly, input int cr_stall, input int cd_mode,
                       input int abort_beat);
    logic [4:0] er;
    bit lk, eu, ei, ec, rdy;
    int n, beat, upd0;
    model(t, hit, dirty, uq, er, lk, eu, ei, ec);
    upd0 = upd_total;
    ac_valid = 1; ac_addr = addr; ac_snoop = t[3:0]; ac_prot = 3'($urandom);
    n = 0;
    while (!ac_ready_o && n < 50) begin step(); n++; end
    check("ac_ready_idle", ac_ready_o, 1);
    step();
    ac_valid = 0; ac_addr = {$urandom, $urandom}; ac_snoop = 4'($urandom);
    check("ac_ready_busy", ac_ready_o, 0);
    if (lk) begin
      check("lu_req", lu_req_o, 1);
      check("lu_addr", lu_addr_o, {addr[AW-1:5], 5'b0});
      for (int i = 0; i < gnt_dly; i++) begin
        step();
        check("lu_req_hold", lu_req_o, 1);
        check("ac_ready_lreq", ac_ready_o, 0);
      end
      lu_gnt = 1; step(); lu_gnt = 0;
      check("lu_req_drop", lu_req_o, 0);
      for (int i = 0; i < rv_dly; i++) begin
        step();
        check("cr_valid_early", cr_valid_o, 0);
      end
      lu_rvalid = 1; lu_hit = hit; lu_dirty = dirty; lu_uniq = uq; lu_data = line;
      step();
      lu_rvalid = 0; lu_hit = 1'($urandom); lu_dirty = 1'($urandom);
      lu_uniq = 1'($urandom); lu_data = '1;
    end else begin
      check("no_lu_req", lu_req_o, 0);
    end
    check("cr_valid", cr_valid_o, 1);
    check("cr_resp", cr_resp_o, er);
    for (int i = 0; i < cr_stall; i++) begin
      step();
      check("cr_valid_hold", cr_valid_o, 1);
      check("cr_resp_hold", cr_resp_o, er);
      check("ac_ready_resp", ac_ready_o, 0);
      check("cd_before_cr", cd_valid_o, 0);
    end
    cr_ready = 1; step(); cr_ready = 0;
    check("cr_valid_drop", cr_valid_o, 0);
    check("upd_count", upd_total - upd0, eu);
    if (eu) check("upd_kind", {upd_inv_seen, upd_cln_seen}, {ei, ec});
    if (er[0]) begin
      beat = 0; n = 0;
      while (beat < LB && n < 100) begin
        rdy = (cd_mode == 0) ? 1'b1 : (cd_mode == 1) ? 1'(n % 2) : 1'($urandom);
        cd_ready = rdy;
        check("cd_valid", cd_valid_o, 1);
        check("cd_data", cd_data_o, line[beat*DW +: DW]);
        check("cd_last", cd_last_o, (beat == LB - 1));
        if (beat == abort_beat) begin
          rst_n = 0;
          #1;
          check_all_zero("abort");
          cd_ready = 0;
          return;
        end
        step(); n++;
        if (rdy) beat++;
      end
      cd_ready = 0;
    end
    check("cd_idle", cd_valid_o, 0);
    check("ac_ready_back", ac_ready_o, 1);
  endtask

  function automatic logic [DW*LB-1:0] rand_line();
    logic [DW*LB-1:0] l;
    for (int i = 0; i < DW * LB / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  initial begin
    logic [DW*LB-1:0] ramp;
    ramp = {64'd3, 64'd2, 64'd1, 64'd0};
    rst_n = 0; ac_valid = 0; cr_ready = 0; cd_ready = 0; lu_gnt = 0; lu_rvalid = 0;
    lu_hit = 0; lu_dirty = 0; lu_uniq = 0; ac_addr = '0; ac_snoop = '0; ac_prot = '0;
    lu_data = '0;
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1;
    step();
    check("ac_ready_after_reset", ac_ready_o, 1);

    // ReadShared hit dirty unique, ramp data.
    snoop(1, 64'h0000_1234_5678_9ABC, 1, 1, 1, ramp, 0, 0, 0, 0, -1);
    // ReadUnique hit clean shared with toggling CD ready.
    snoop(4, 64'hFFFF_0000_DEAD_BEEF, 1, 0, 0, rand_line(), 0, 0, 0, 1, -1);
    // MakeInvalid hit dirty, then a miss.
    snoop(7, 64'h40, 1, 1, 0, rand_line(), 0, 1, 0, 0, -1);
    snoop(1, 64'h80, 0, 1, 1, rand_line(), 0, 0, 0, 0, -1);
    // DVM message and reserved type.
    snoop(9, 64'h100, 1, 1, 1, rand_line(), 0, 0, 0, 0, -1);
    snoop(12, 64'h140, 1, 1, 1, rand_line(), 0, 0, 1, 0, -1);
    // Long grant delay and long response stall.
    snoop(2, 64'h7_0000_001F, 1, 0, 0, rand_line(), 5, 0, 10, 0, -1);
    // Reset during beat 2, then a fresh snoop must start at beat 0.
    snoop(1, 64'h200, 1, 0, 1, ramp, 0, 0, 0, 0, 2);
    step();
    check_all_zero("in_reset");
    rst_n = 1;
    step();
    snoop(0, 64'h240, 1, 1, 1, ramp, 0, 0, 0, 0, -1);

    for (int k = 0; k < 30; k++) begin
      snoop($urandom_range(0, 15), {$urandom, $urandom}, 1'($urandom), 1'($urandom),
            1'($urandom), rand_line(), $urandom_range(0, 3), $urandom_range(0, 2),
            $urandom_range(0, 3), 2, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
